microsequencer: RTL and testbench
=================================

# microsequencer

Next-state engine of the microprogrammed control unit. Holds the 7-bit control state register that addresses the microstore. Each cycle it computes the next state from the microstore's sequencing fields, the decoded instruction, and the datapath/memory condition inputs. Adds a one-level micro-subroutine return register and a memory-wait watchdog.

## Interface
- `STATE_W`, 7: state width; must match the microstore address.
- `FETCH_STATE`, 7'd0: reset and fetch entry state.
- `FAULT_STATE`, 7'd5: state forced on memory-wait timeout.
- `WAIT_LIMIT`, 255: maximum consecutive hold cycles in a wait state.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ir` in 32: instruction register contents, feeding the encoder.
- `ns_sel` in 3: next-state select field from the control word.
- `cond_sel` in 2: condition select. 00 `moc`, 01 `alu_zero`, 10 `alu_neg`, 11 constant 0.
- `inv` in 1: inverts the selected condition.
- `cr_addr` in 7: literal target address from the control word.
- `mcall` in 1: on a transfer to `cr_addr`, save the return address.
- `moc` in 1: memory operation complete.
- `alu_zero` in 1: ALU zero flag.
- `alu_neg` in 1: ALU negative flag.
- `current_state` out 7: registered state, addresses the microstore.
- `mem_timeout` out 1: one-cycle pulse when the watchdog fires.

## Operation
- Condition: `cond = mux(cond_sel) ^ inv`.
- `ns_sel` decode:
  - 000: encoder(ir)
  - 001: `FETCH_STATE`
  - 010: `cr_addr`
  - 011: `current_state + 1`
  - 100: `cond ? cr_addr : current_state + 1`
  - 101: `cond ? cr_addr : encoder(ir)`
  - 110: wait; `cond ? current_state + 1 : current_state`
  - 111: return; next state is `ret_reg`
- Incrementer is modulo 2^7: 7'd127 + 1 = 7'd0.
- Encoder mapping, fixed by package constants:
  - opcode 6'h00 with funct 6'h21 -> 7'd6
  - opcode 6'h09 -> 7'd17
  - opcode 6'h23 -> 7'd31
  - opcode 6'h2B -> 7'd34
  - opcode 6'h04 -> 7'd37
  - opcode 6'h02 -> 7'd11
  - all other opcode/funct combinations -> 7'd1 (skip instruction)
- Return register `ret_reg`:
  - Loads `current_state + 1` when `mcall` = 1 and the selected next state actually comes from `cr_addr`.
  - This covers 010, and 100/101 only when `cond` = 1.
  - `mcall` is ignored for every other `ns_sel`, including 111.
  - `ret_reg` holds its value otherwise.
- Watchdog `wait_cnt`:
  - Increments each cycle `ns_sel` = 110 and `cond` = 0, i.e. while holding.
  - Clears on any other cycle.
  - On the hold cycle where `wait_cnt` = `WAIT_LIMIT`: next state is `FAULT_STATE`, `mem_timeout` = 1 for that cycle, and `wait_cnt` clears.
- Reset: `current_state`, `ret_reg` and `wait_cnt` all load 0; `current_state` takes `FETCH_STATE`; `mem_timeout` = 0.
  - Reset has priority over every select, call and timeout in the same cycle.

## Timing
- `current_state` changes only on a rising `clk`. The microstore decodes it combinationally within the same cycle.
- Next-state logic is fully combinational from the control word, `ir`, flags and `current_state`. Exactly one state per cycle; no bubbles.
- Wait semantics with `moc`:
  - `moc` sampled 1 on the hold cycle: advance at the next edge.
  - `moc` = 0: hold with no limit on state changes until the watchdog fires.
- `mem_timeout` is combinational from the registered `wait_cnt` and inputs. It is asserted in the same cycle the decision to go to `FAULT_STATE` is taken, and deasserts the following cycle.
- Reset asserted mid-wait or mid-subroutine: the next edge gives `FETCH_STATE` with all counters and registers cleared. No pending timeout survives.

## Structure
- Package `control_pkg` holds:
  - `ns_sel` and `cond_sel` encodings as localparams
  - opcode/funct constants
  - encoder target state constants
  - `STATE_W`
- Sub-module `state_encoder`: purely combinational `ir` -> 7-bit state, using the package constants.
- The top level holds the state register, `ret_reg`, `wait_cnt`, the condition mux and the next-state mux.

## Test plan
- Reset held 2 cycles while `ns_sel` = 011 -> `current_state` = 0 and `mem_timeout` = 0. After release, the states step 1, 2, 3.
- `current_state` = 7'd127, `ns_sel` = 011 -> next `current_state` = 7'd0.
- `ns_sel` = 110, `cond_sel` = 00, `moc` low 3 cycles then high -> state held 3 cycles, then advances by 1. No timeout.
- `ir` opcode 6'h23 with `ns_sel` = 000 -> 7'd31. `ir` opcode 6'h3F -> 7'd1.
- `ns_sel` = 100, `cond_sel` = 01, `alu_zero` = 1, `inv` = 1, `cr_addr` = 40 -> state + 1. With `inv` = 0 -> 40.
- From state 12: `ns_sel` = 010, `cr_addr` = 50, `mcall` = 1 -> 50. Later `ns_sel` = 111 -> 13.
- `WAIT_LIMIT` = 4, wait with `moc` = 0 -> 4 hold cycles, then a `mem_timeout` pulse and next state 7'd5.

Source files
------------

// File: rtl/control_pkg.sv
// Shared constants for the microprogrammed control unit: sequencing field
// encodings, instruction opcode/funct values and the microstore entry
// states the instruction encoder dispatches to.
package control_pkg;

  localparam int STATE_W = 7;

  // Next-state select field of the control word
  localparam logic [2:0] NS_ENCODE  = 3'b000;
  localparam logic [2:0] NS_FETCH   = 3'b001;
  localparam logic [2:0] NS_LITERAL = 3'b010;
  localparam logic [2:0] NS_INC     = 3'b011;
  localparam logic [2:0] NS_BR_INC  = 3'b100;
  localparam logic [2:0] NS_BR_ENC  = 3'b101;
  localparam logic [2:0] NS_WAIT    = 3'b110;
  localparam logic [2:0] NS_RETURN  = 3'b111;

  // Condition select field of the control word
  localparam logic [1:0] COND_MOC   = 2'b00;
  localparam logic [1:0] COND_ZERO  = 2'b01;
  localparam logic [1:0] COND_NEG   = 2'b10;
  localparam logic [1:0] COND_FALSE = 2'b11;

  // Instruction fields recognised by the encoder
  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_J       = 6'h02;

  // Microstore entry points for each recognised instruction
  localparam logic [STATE_W-1:0] ST_ADDU  = 7'd6;
  localparam logic [STATE_W-1:0] ST_ADDIU = 7'd17;
  localparam logic [STATE_W-1:0] ST_LW    = 7'd31;
  localparam logic [STATE_W-1:0] ST_SW    = 7'd34;
  localparam logic [STATE_W-1:0] ST_BEQ   = 7'd37;
  localparam logic [STATE_W-1:0] ST_J     = 7'd11;
  localparam logic [STATE_W-1:0] ST_SKIP  = 7'd1;

endpackage

// File: rtl/state_encoder.sv
// Instruction dispatch encoder: maps the opcode (and funct for R-type)
// of the instruction register to the microstore entry state. Anything not
// recognised goes to the skip-instruction state.
module state_encoder #(
  parameter int STATE_W = control_pkg::STATE_W
) (
  input  logic [31:0]        ir_i,
  output logic [STATE_W-1:0] encState_o
);
  import control_pkg::*;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unusedIrBits;

  assign opcode       = ir_i[31:26];
  assign funct        = ir_i[5:0];
  assign unusedIrBits = ^ir_i[25:6];

  // Opcode lookup; only R-type looks at funct
  always_comb begin
    encState_o = STATE_W'(ST_SKIP);
    case (opcode)
      OP_RTYPE: if (funct == FUNCT_ADDU) encState_o = STATE_W'(ST_ADDU);
      OP_ADDIU: encState_o = STATE_W'(ST_ADDIU);
      OP_LW:    encState_o = STATE_W'(ST_LW);
      OP_SW:    encState_o = STATE_W'(ST_SW);
      OP_BEQ:   encState_o = STATE_W'(ST_BEQ);
      OP_J:     encState_o = STATE_W'(ST_J);
      default:  encState_o = STATE_W'(ST_SKIP);
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// Next-state engine of the microprogrammed control unit. Holds the control
// state register that addresses the microstore, a one-level subroutine
// return register and a watchdog that bounds memory-wait hold loops.
module microsequencer #(
  parameter int                 STATE_W     = control_pkg::STATE_W,
  parameter logic [STATE_W-1:0] FETCH_STATE = STATE_W'(0),
  parameter logic [STATE_W-1:0] FAULT_STATE = STATE_W'(5),
  parameter int                 WAIT_LIMIT  = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        ir,
  input  logic [2:0]         ns_sel,
  input  logic [1:0]         cond_sel,
  input  logic               inv,
  input  logic [STATE_W-1:0] cr_addr,
  input  logic               mcall,
  input  logic               moc,
  input  logic               alu_zero,
  input  logic               alu_neg,
  output logic [STATE_W-1:0] current_state,
  output logic               mem_timeout
);
  import control_pkg::*;

  localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] retAddr_q, retAddr_d;
  logic [CNT_W-1:0]   waitCnt_q, waitCnt_d;
  logic [STATE_W-1:0] encState;
  logic [STATE_W-1:0] incState;
  logic               condRaw;
  logic               condVal;
  logic               takeLiteral;

  state_encoder #(.STATE_W(STATE_W)) u_encoder (
    .ir_i       (ir),
    .encState_o (encState)
  );

  assign incState      = state_q + STATE_W'(1);
  assign current_state = state_q;

  // Condition mux; the constant-0 leg combined with inv gives "always"
  always_comb begin
    condRaw = 1'b0;
    case (cond_sel)
      COND_MOC:   condRaw = moc;
      COND_ZERO:  condRaw = alu_zero;
      COND_NEG:   condRaw = alu_neg;
      COND_FALSE: condRaw = 1'b0;
      default:    condRaw = 1'b0;
    endcase
    condVal = condRaw ^ inv;
  end

  // Next-state mux, call bookkeeping and the wait watchdog
  always_comb begin
    state_d     = incState;
    retAddr_d   = retAddr_q;
    waitCnt_d   = '0;
    mem_timeout = 1'b0;
    takeLiteral = 1'b0;
    case (ns_sel)
      NS_ENCODE:  state_d = encState;
      NS_FETCH:   state_d = FETCH_STATE;
      NS_LITERAL: begin
        state_d     = cr_addr;
        takeLiteral = 1'b1;
      end
      NS_INC:     state_d = incState;
      NS_BR_INC: begin
        state_d     = condVal ? cr_addr : incState;
        takeLiteral = condVal;
      end
      NS_BR_ENC: begin
        state_d     = condVal ? cr_addr : encState;
        takeLiteral = condVal;
      end
      NS_WAIT: begin
        if (condVal) begin
          state_d = incState;
        end else if (waitCnt_q == CNT_W'(WAIT_LIMIT)) begin
          state_d     = FAULT_STATE;
          mem_timeout = !reset;
        end else begin
          state_d   = state_q;
          waitCnt_d = waitCnt_q + CNT_W'(1);
        end
      end
      NS_RETURN:  state_d = retAddr_q;
      default:    state_d = incState;
    endcase
    if (mcall && takeLiteral) retAddr_d = incState;
  end

  // Registers; reset overrides any select, call or pending timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH_STATE;
      retAddr_q <= '0;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      retAddr_q <= retAddr_d;
      waitCnt_q <= waitCnt_d;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for the microsequencer: directed scenarios from the
// feature list followed by a randomized run, all compared against a
// behavioural model of the sequencing rules kept inside the bench.
module tb_microsequencer;

  localparam int LIMIT = 4;

  logic        clk;
  logic        reset;
  logic [31:0] ir;
  logic [2:0]  ns_sel;
  logic [1:0]  cond_sel;
  logic        inv;
  logic [6:0]  cr_addr;
  logic        mcall;
  logic        moc;
  logic        alu_zero;
  logic        alu_neg;
  logic [6:0]  current_state;
  logic        mem_timeout;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the sequencer
  int   mState = 0;
  int   mRet   = 0;
  int   mWait  = 0;
  int   expState;
  logic expTimeout;
  logic obsTimeout;

  microsequencer #(
    .STATE_W     (7),
    .FETCH_STATE (7'd0),
    .FAULT_STATE (7'd5),
    .WAIT_LIMIT  (LIMIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ir            (ir),
    .ns_sel        (ns_sel),
    .cond_sel      (cond_sel),
    .inv           (inv),
    .cr_addr       (cr_addr),
    .mcall         (mcall),
    .moc           (moc),
    .alu_zero      (alu_zero),
    .alu_neg       (alu_neg),
    .current_state (current_state),
    .mem_timeout   (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dispatch table for the instruction register
  function automatic int encodeModel(input logic [31:0] instr);
    int op;
    int fn;
    op = int'(instr[31:26]);
    fn = int'(instr[5:0]);
    if (op == 'h00 && fn == 'h21) return 6;
    if (op == 'h09) return 17;
    if (op == 'h23) return 31;
    if (op == 'h2B) return 34;
    if (op == 'h04) return 37;
    if (op == 'h02) return 11;
    return 1;
  endfunction

  // Advance the model by one clock using the inputs currently applied
  task automatic predict();
    int   plus1;
    int   nxt;
    logic c;
    logic toLiteral;
    expTimeout = 1'b0;
    if (reset) begin
      mState = 0; mRet = 0; mWait = 0;
      expState = 0;
      return;
    end
    case (cond_sel)
      2'd0:    c = moc;
      2'd1:    c = alu_zero;
      2'd2:    c = alu_neg;
      default: c = 1'b0;
    endcase
    c = c ^ inv;
    plus1 = (mState + 1) % 128;
    toLiteral = 1'b0;
    nxt = plus1;
    case (ns_sel)
      3'd0: nxt = encodeModel(ir);
      3'd1: nxt = 0;
      3'd2: begin nxt = int'(cr_addr); toLiteral = 1'b1; end
      3'd3: nxt = plus1;
      3'd4: begin nxt = c ? int'(cr_addr) : plus1; toLiteral = c; end
      3'd5: begin nxt = c ? int'(cr_addr) : encodeModel(ir); toLiteral = c; end
      3'd6: nxt = c ? plus1 : mState;
      default: nxt = mRet;
    endcase
    if (ns_sel == 3'd6 && !c) begin
      if (mWait == LIMIT) begin
        nxt = 5; expTimeout = 1'b1; mWait = 0;
      end else begin
        mWait = mWait + 1;
      end
    end else begin
      mWait = 0;
    end
    if (mcall && toLiteral) mRet = plus1;
    mState = nxt;
    expState = nxt;
  endtask

  // One clock: sample the combinational pulse mid-cycle, update the model,
  // then let the edge happen and settle
  task automatic applyStimulus();
    @(negedge clk);
    obsTimeout = mem_timeout;
    predict();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    ir = 32'h0; ns_sel = 3'd3; cond_sel = 2'd3; inv = 1'b0; cr_addr = 7'd0;
    mcall = 1'b0; moc = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    setIdle();
    for (int i = 0; i < 2; i++) applyStimulus();
    checks++;
    if (current_state !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_state got %0d expected 0", current_state);
    end
    checks++;
    if (obsTimeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_timeout got %b expected 0", obsTimeout);
    end
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus();
      checks++;
      if (current_state !== 7'(i)) begin
        errors++;
        $display("[TB] FAIL reset_step%0d got %0d expected %0d", i, current_state, i);
      end
    end
  endtask

  task automatic test_wrap();
    setIdle();
    ns_sel = 3'd2; cr_addr = 7'd127;
    applyStimulus();
    ns_sel = 3'd3;
    applyStimulus();
    checks++;
    if (current_state !== 7'd0) begin
      errors++;
      $display("[TB] FAIL wrap got %0d expected 0", current_state);
    end
  endtask

  task automatic test_wait_moc();
    int start;
    setIdle();
    start = mState;
    ns_sel = 3'd6; cond_sel = 2'd0; moc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checks++;
      if (current_state !== 7'(start) || obsTimeout !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wait_hold%0d got %0d/%b expected %0d/0", i, current_state, obsTimeout, start);
      end
    end
    moc = 1'b1;
    applyStimulus();
    checks++;
    if (current_state !== 7'((start + 1) % 128) || obsTimeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wait_release got %0d/%b expected %0d/0", current_state, obsTimeout, (start + 1) % 128);
    end
  endtask

  task automatic test_encoder();
    logic [5:0] ops [0:7];
    int         want [0:7];
    ops = '{6'h23, 6'h3F, 6'h09, 6'h2B, 6'h04, 6'h02, 6'h00, 6'h00};
    want = '{31, 1, 17, 34, 37, 11, 6, 1};
    setIdle();
    ns_sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      ir = {ops[i], 20'($urandom), (i == 7) ? 6'h20 : 6'h21};
      applyStimulus();
      checks++;
      if (current_state !== 7'(want[i])) begin
        errors++;
        $display("[TB] FAIL encode_op%0h got %0d expected %0d", ops[i], current_state, want[i]);
      end
    end
  endtask

  task automatic test_branch();
    int start;
    setIdle();
    start = mState;
    ns_sel = 3'd4; cond_sel = 2'd1; alu_zero = 1'b1; inv = 1'b1; cr_addr = 7'd40;
    applyStimulus();
    checks++;
    if (current_state !== 7'((start + 1) % 128)) begin
      errors++;
      $display("[TB] FAIL branch_inv got %0d expected %0d", current_state, (start + 1) % 128);
    end
    inv = 1'b0;
    applyStimulus();
    checks++;
    if (current_state !== 7'd40) begin
      errors++;
      $display("[TB] FAIL branch_taken got %0d expected 40", current_state);
    end
  endtask

  task automatic test_call_return();
    setIdle();
    ns_sel = 3'd2; cr_addr = 7'd12;
    applyStimulus();
    cr_addr = 7'd50; mcall = 1'b1;
    applyStimulus();
    checks++;
    if (current_state !== 7'd50) begin
      errors++;
      $display("[TB] FAIL call got %0d expected 50", current_state);
    end
    ns_sel = 3'd3; mcall = 1'b1;
    applyStimulus();
    applyStimulus();
    ns_sel = 3'd7;
    applyStimulus();
    checks++;
    if (current_state !== 7'd13) begin
      errors++;
      $display("[TB] FAIL return got %0d expected 13", current_state);
    end
  endtask

  task automatic test_timeout();
    int start;
    setIdle();
    ns_sel = 3'd2; cr_addr = 7'd20;
    applyStimulus();
    start = 20;
    ns_sel = 3'd6; cond_sel = 2'd0; moc = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      applyStimulus();
      checks++;
      if (current_state !== 7'(start) || obsTimeout !== 1'b0) begin
        errors++;
        $display("[TB] FAIL timeout_hold%0d got %0d/%b expected %0d/0", i, current_state, obsTimeout, start);
      end
    end
    applyStimulus();
    checks++;
    if (current_state !== 7'd5 || obsTimeout !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_fire got %0d/%b expected 5/1", current_state, obsTimeout);
    end
    ns_sel = 3'd3;
    applyStimulus();
    checks++;
    if (obsTimeout !== 1'b0 || current_state !== 7'd6) begin
      errors++;
      $display("[TB] FAIL timeout_after got %0d/%b expected 6/0", current_state, obsTimeout);
    end
  endtask

  task automatic test_reset_mid_wait();
    setIdle();
    ns_sel = 3'd2; cr_addr = 7'd60; mcall = 1'b1;
    applyStimulus();
    ns_sel = 3'd6; cond_sel = 2'd0; mcall = 1'b0;
    for (int i = 0; i < LIMIT; i++) applyStimulus();
    reset = 1'b1;
    applyStimulus();
    checks++;
    if (current_state !== 7'd0 || obsTimeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_wait got %0d/%b expected 0/0", current_state, obsTimeout);
    end
    reset = 1'b0;
    applyStimulus();
    checks++;
    if (current_state !== 7'd0 || obsTimeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wait_cleared got %0d/%b expected 0/0", current_state, obsTimeout);
    end
    ns_sel = 3'd7;
    applyStimulus();
    checks++;
    if (current_state !== 7'd0) begin
      errors++;
      $display("[TB] FAIL ret_cleared got %0d expected 0", current_state);
    end
  endtask

  task automatic test_random();
    logic [5:0] opPick [0:6];
    opPick = '{6'h00, 6'h09, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
    for (int n = 0; n < 2000; n++) begin
      reset    = ($urandom_range(0, 59) == 0);
      ns_sel   = ($urandom_range(0, 3) == 0) ? 3'd6 : 3'($urandom);
      cond_sel = 2'($urandom);
      inv      = ($urandom_range(0, 3) == 0);
      cr_addr  = 7'($urandom);
      mcall    = 1'($urandom);
      moc      = ($urandom_range(0, 4) == 0);
      alu_zero = 1'($urandom);
      alu_neg  = 1'($urandom);
      ir       = {opPick[$urandom_range(0, 6)], 20'($urandom),
                  ($urandom_range(0, 1) == 0) ? 6'h21 : 6'($urandom)};
      applyStimulus();
      checks++;
      if (current_state !== 7'(expState) || obsTimeout !== expTimeout) begin
        errors++;
        $display("[TB] FAIL random%0d ns_sel=%0d got %0d/%b expected %0d/%b",
                 n, ns_sel, current_state, obsTimeout, expState, expTimeout);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_wait_moc();
    test_encoder();
    test_branch();
    test_call_return();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
